// File: rtl/game_sequencer_if.sv
// -----------------------------------------------------------------------------
// game_sequencer_if
// Signal bundle between the match controller and its surroundings (sync
// generator, board keys, ball/paddle datapath).
//   vsync        frame sync, active high, asynchronous
//   key_start_n  start/restart key, active low, asynchronous
//   key_pause_n  pause toggle key, active low, asynchronous
//   goal_evt     one-clock goal pulse from the datapath
//   move_tick    one-clock advance enable for ball and paddle
//   ball_reset   one-clock ball reload pulse
//   goals        thermometer goal count, LSB first
//   game_over    high while the match is over
//   paused       high while paused
//   state        encoded match state for debug
// master: the environment side (drives keys, sync and goal events).
// slave : the sequencer side (drives the control outputs).
// -----------------------------------------------------------------------------
interface game_sequencer_if;
    logic       vsync;
    logic       key_start_n;
    logic       key_pause_n;
    logic       goal_evt;
    logic       move_tick;
    logic       ball_reset;
    logic [7:0] goals;
    logic       game_over;
    logic       paused;
    logic [2:0] state;

    modport master (
        output vsync, key_start_n, key_pause_n, goal_evt,
        input  move_tick, ball_reset, goals, game_over, paused, state
    );

    modport slave (
        input  vsync, key_start_n, key_pause_n, goal_evt,
        output move_tick, ball_reset, goals, game_over, paused, state
    );
endinterface

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Match-level controller for the tennis game. Turns the frame sync into a
// frame tick, debounces the keys on that tick, derives the move enable for
// the ball/paddle datapath and runs the match state machine. Owns the goal
// tally.
// Ports:
//   char_clock  system clock, all logic on its rising edge
//   rst_n       synchronous active-low reset
//   bus         game_sequencer_if.slave (keys, vsync, goal_evt in;
//               move_tick, ball_reset, goals, game_over, paused, state out)
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int FRAME_DIV    = 3,   // frames per move_tick while playing (1..15)
    parameter int SERVE_FRAMES = 60,  // frame ticks spent serving (1..255)
    parameter int GOAL_FRAMES  = 30,  // frame ticks spent after a goal (1..255)
    parameter int MAX_GOALS    = 8    // goals that end the match (1..8)
) (
    input  logic             char_clock,
    input  logic             rst_n,
    game_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_GOAL  = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    localparam logic [3:0] DIV_LAST   = 4'(FRAME_DIV - 1);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] GOAL_LAST  = 8'(GOAL_FRAMES - 1);
    localparam logic [3:0] GOAL_LIMIT = 4'(MAX_GOALS);

    // ------------------------------------------------------------------
    // Frame tick and key sampling
    // ------------------------------------------------------------------
    logic [2:0] vsync_sr;     // [0],[1] synchroniser, [2] edge-detect history
    logic       frame_tick;
    logic [1:0] start_sync;
    logic [1:0] pause_sync;
    logic       start_prev;   // key level at the previous frame tick
    logic       pause_prev;
    logic       start_evt;
    logic       pause_evt;

    // NOTE: every flop here is assigned with <= so all of them sample the
    // pre-edge values; a blocking assignment would collapse the
    // synchroniser chain into a single stage.
    always_ff @(posedge char_clock) begin
        if (!rst_n) begin
            vsync_sr   <= '0;
            frame_tick <= 1'b0;
            start_sync <= '0;
            pause_sync <= '0;
            start_prev <= 1'b0;
            pause_prev <= 1'b0;
        end else begin
            vsync_sr   <= {vsync_sr[1:0], bus.vsync};
            frame_tick <= vsync_sr[1] & ~vsync_sr[2];
            start_sync <= {start_sync[0], bus.key_start_n};
            pause_sync <= {pause_sync[0], bus.key_pause_n};
            // Sampling only once per frame is the debounce.
            if (frame_tick) begin
                start_prev <= start_sync[1];
                pause_prev <= pause_sync[1];
            end
        end
    end

    // A press is a 1 -> 0 change between consecutive frame samples, so a
    // held key yields exactly one event.
    assign start_evt = frame_tick & start_prev & ~start_sync[1];
    assign pause_evt = frame_tick & pause_prev & ~pause_sync[1];

    // ------------------------------------------------------------------
    // Goal arithmetic
    // ------------------------------------------------------------------
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    logic [7:0] goals_q;
    logic [7:0] goals_inc;
    logic       goal_hit;

    // The tally saturates at all ones.
    assign goals_inc = (goals_q == 8'hFF) ? goals_q : {goals_q[6:0], 1'b1};
    assign goal_hit  = (popcount8(goals_inc) == GOAL_LIMIT);

    // ------------------------------------------------------------------
    // Match state machine with registered outputs
    // ------------------------------------------------------------------
    state_t     state_q;
    logic [7:0] frame_cnt;
    logic [3:0] div_cnt;
    logic       move_tick_q;
    logic       ball_reset_q;
    logic       game_over_q;
    logic       paused_q;

    always_ff @(posedge char_clock) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            frame_cnt    <= '0;
            div_cnt      <= '0;
            goals_q      <= '0;
            move_tick_q  <= 1'b0;
            ball_reset_q <= 1'b0;
            game_over_q  <= 1'b0;
            paused_q     <= 1'b0;
        end else begin
            // Pulses default low so each lasts exactly one clock.
            move_tick_q  <= 1'b0;
            ball_reset_q <= 1'b0;

            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_evt) begin
                        goals_q      <= '0;
                        ball_reset_q <= 1'b1;
                        frame_cnt    <= '0;
                        game_over_q  <= 1'b0;
                        state_q      <= ST_SERVE;
                    end
                end

                ST_SERVE: begin
                    if (frame_tick) begin
                        if (frame_cnt == SERVE_LAST) begin
                            div_cnt <= '0;
                            state_q <= ST_PLAY;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end

                ST_PLAY: begin
                    // The divider freezes on the tick that pauses, so the
                    // held value is the one seen at the press.
                    if (frame_tick && (bus.goal_evt || !pause_evt)) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt     <= '0;
                            move_tick_q <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + 4'd1;
                        end
                    end

                    if (bus.goal_evt) begin
                        goals_q   <= goals_inc;
                        frame_cnt <= '0;
                        if (goal_hit) begin
                            game_over_q <= 1'b1;
                            state_q     <= ST_OVER;
                        end else begin
                            state_q <= ST_GOAL;
                        end
                    end else if (pause_evt) begin
                        paused_q <= 1'b1;
                        state_q  <= ST_PAUSE;
                    end
                end

                ST_PAUSE: begin
                    if (start_evt) begin
                        paused_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (pause_evt) begin
                        paused_q <= 1'b0;
                        state_q  <= ST_PLAY;
                    end
                end

                ST_GOAL: begin
                    if (frame_tick) begin
                        if (frame_cnt == GOAL_LAST) begin
                            frame_cnt    <= '0;
                            ball_reset_q <= 1'b1;
                            state_q      <= ST_SERVE;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end

                default: begin
                    paused_q    <= 1'b0;
                    game_over_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.move_tick  = move_tick_q;
    assign bus.ball_reset = ball_reset_q;
    assign bus.goals      = goals_q;
    assign bus.game_over  = game_over_q;
    assign bus.paused     = paused_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
// Directed bench for game_sequencer (FRAME_DIV=3, SERVE_FRAMES=60,
// GOAL_FRAMES=30, MAX_GOALS=2). Expected values are queued as each step's
// stimulus is applied and compared in order once the step has completed.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

    logic char_clock;
    logic rst_n;

    game_sequencer_if bus ();

    game_sequencer #(
        .FRAME_DIV    (3),
        .SERVE_FRAMES (60),
        .GOAL_FRAMES  (30),
        .MAX_GOALS    (2)
    ) dut (
        .char_clock (char_clock),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    initial char_clock = 1'b0;
    always #5 char_clock = ~char_clock;

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic expect_val(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic check(input logic [31:0] observed);
        string       tag;
        logic [31:0] expected;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=0x%0h", observed);
        end else begin
            tag      = tag_q.pop_front();
            expected = exp_q.pop_front();
            assert (observed === expected) else begin
                failures++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Pulse monitor, sampled on the falling edge
    // ------------------------------------------------------------------
    int   frame_no = 0;
    int   move_cnt = 0;
    int   ball_cnt = 0;
    int   move_wide = 0;
    int   ball_wide = 0;
    logic move_prev = 1'b0;
    logic ball_prev = 1'b0;
    int   move_frames[$];

    always @(negedge char_clock) begin
        if (bus.move_tick) begin
            move_cnt <= move_cnt + 1;
            move_frames.push_back(frame_no);
            if (move_prev) move_wide <= move_wide + 1;
        end
        if (bus.ball_reset) begin
            ball_cnt <= ball_cnt + 1;
            if (ball_prev) ball_wide <= ball_wide + 1;
        end
        move_prev <= bus.move_tick;
        ball_prev <= bus.ball_reset;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (always entered on a falling edge)
    // ------------------------------------------------------------------
    // One 20-clock frame: vsync high for 4 clocks. The frame tick is
    // consumed by the state machine at the 4th rising edge after the rise;
    // with_goal lands goal_evt on that same edge.
    task automatic frame(input bit with_goal);
        bus.vsync = 1'b1;
        repeat (3) @(negedge char_clock);
        if (with_goal) bus.goal_evt = 1'b1;
        @(negedge char_clock);
        bus.goal_evt = 1'b0;
        bus.vsync    = 1'b0;
        repeat (16) @(negedge char_clock);
        frame_no++;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0);
    endtask

    task automatic pulse_goal();
        bus.goal_evt = 1'b1;
        @(negedge char_clock);
        bus.goal_evt = 1'b0;
    endtask

    int move_base;
    int ball_base;
    int q_base;
    int play_frame;
    int resume_frame;

    initial begin
        rst_n           = 1'b0;
        bus.vsync       = 1'b0;
        bus.key_start_n = 1'b1;
        bus.key_pause_n = 1'b1;
        bus.goal_evt    = 1'b0;

        // Reset for two clocks.
        repeat (2) @(posedge char_clock);
        @(negedge char_clock);
        expect_val("reset_state", 32'd0);
        expect_val("reset_goals", 32'h00);
        expect_val("reset_move_tick", 32'd0);
        expect_val("reset_ball_reset", 32'd0);
        expect_val("reset_game_over", 32'd0);
        expect_val("reset_paused", 32'd0);
        rst_n = 1'b1;
        check(32'(bus.state));
        check(32'(bus.goals));
        check(32'(bus.move_tick));
        check(32'(bus.ball_reset));
        check(32'(bus.game_over));
        check(32'(bus.paused));

        // Start: one frame released, then three frames with the key held.
        frame(1'b0);
        ball_base = ball_cnt;
        expect_val("start_ball_reset_count", 32'd1);
        expect_val("start_state", 32'd1);
        expect_val("start_goals", 32'h00);
        bus.key_start_n = 1'b0;
        frames(3);
        bus.key_start_n = 1'b1;
        check(32'(ball_cnt - ball_base));
        check(32'(bus.state));
        check(32'(bus.goals));

        // Serve: two ticks already counted; 57 more leaves it one short.
        expect_val("serve_59_state", 32'd1);
        frames(57);
        check(32'(bus.state));
        expect_val("serve_60_state", 32'd2);
        expect_val("serve_move_count", 32'd0);
        frame(1'b0);
        play_frame = frame_no - 1;
        check(32'(bus.state));
        check(32'(move_cnt));

        // Tick rate: 12 frames of play give four ticks, three frames apart.
        move_base = move_cnt;
        q_base    = move_frames.size();
        expect_val("play_move_count", 32'd4);
        expect_val("play_move_wide", 32'd0);
        for (int k = 1; k <= 4; k++) expect_val($sformatf("play_move_frame_%0d", k), 32'(play_frame + 3 * k));
        frames(12);
        check(32'(move_cnt - move_base));
        check(32'(move_wide));
        for (int k = 0; k < 4; k++) begin
            if (move_frames.size() > q_base + k) check(32'(move_frames[q_base + k]));
            else check(32'hFFFF_FFFF);
        end

        // Pause at divider 1: ten frames frozen, goal ignored, key held.
        frame(1'b0);
        move_base = move_cnt;
        expect_val("pause_paused", 32'd1);
        expect_val("pause_state", 32'd5);
        bus.key_pause_n = 1'b0;
        frame(1'b0);
        check(32'(bus.paused));
        check(32'(bus.state));
        expect_val("pause_move_count", 32'd0);
        expect_val("pause_goals", 32'h00);
        expect_val("pause_hold_state", 32'd5);
        frames(4);
        bus.key_pause_n = 1'b1;
        pulse_goal();
        frames(5);
        check(32'(move_cnt - move_base));
        check(32'(bus.goals));
        check(32'(bus.state));

        // Resume: next tick exactly two frames later.
        expect_val("resume_state", 32'd2);
        expect_val("resume_paused", 32'd0);
        bus.key_pause_n = 1'b0;
        frame(1'b0);
        resume_frame = frame_no - 1;
        bus.key_pause_n = 1'b1;
        check(32'(bus.state));
        check(32'(bus.paused));
        expect_val("resume_plus1_moves", 32'd0);
        frame(1'b0);
        check(32'(move_cnt - move_base));
        expect_val("resume_plus2_moves", 32'd1);
        expect_val("resume_tick_frame", 32'(resume_frame + 2));
        frame(1'b0);
        check(32'(move_cnt - move_base));
        check(32'(move_frames[$]));

        // Goal: tally, GOAL state, 30 frames then one ball reload.
        move_base = move_cnt;
        ball_base = ball_cnt;
        expect_val("goal1_goals", 32'h01);
        expect_val("goal1_state", 32'd3);
        pulse_goal();
        check(32'(bus.goals));
        check(32'(bus.state));
        expect_val("goal_29_state", 32'd3);
        expect_val("goal_29_ball", 32'd0);
        frames(29);
        check(32'(bus.state));
        check(32'(ball_cnt - ball_base));
        expect_val("goal_30_state", 32'd1);
        expect_val("goal_30_ball", 32'd1);
        expect_val("goal_moves", 32'd0);
        frame(1'b0);
        check(32'(bus.state));
        check(32'(ball_cnt - ball_base));
        check(32'(move_cnt - move_base));

        // Match end at two goals.
        expect_val("reserve_state", 32'd2);
        frames(60);
        check(32'(bus.state));
        expect_val("over_goals", 32'h03);
        expect_val("over_state", 32'd4);
        expect_val("over_game_over", 32'd1);
        pulse_goal();
        check(32'(bus.goals));
        check(32'(bus.state));
        check(32'(bus.game_over));
        expect_val("over_goal_ignored", 32'h03);
        frames(2);
        pulse_goal();
        check(32'(bus.goals));

        // Restart from OVER.
        ball_base = ball_cnt;
        expect_val("restart_goals", 32'h00);
        expect_val("restart_state", 32'd1);
        expect_val("restart_game_over", 32'd0);
        expect_val("restart_ball", 32'd1);
        bus.key_start_n = 1'b0;
        frame(1'b0);
        bus.key_start_n = 1'b1;
        check(32'(bus.goals));
        check(32'(bus.state));
        check(32'(bus.game_over));
        check(32'(ball_cnt - ball_base));

        // Goal and pause event on the same clock: goal wins.
        expect_val("restart_play_state", 32'd2);
        frames(60);
        check(32'(bus.state));
        expect_val("goal_pause_state", 32'd3);
        expect_val("goal_pause_paused", 32'd0);
        expect_val("goal_pause_goals", 32'h01);
        bus.key_pause_n = 1'b0;
        frame(1'b1);
        bus.key_pause_n = 1'b1;
        check(32'(bus.state));
        check(32'(bus.paused));
        check(32'(bus.goals));

        // Reset during GOAL: abort without a ball reload.
        frames(5);
        ball_base = ball_cnt;
        expect_val("abort_state", 32'd0);
        expect_val("abort_goals", 32'h00);
        expect_val("abort_ball", 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge char_clock);
        check(32'(bus.state));
        check(32'(bus.goals));
        check(32'(ball_cnt - ball_base));
        rst_n = 1'b1;
        expect_val("post_abort_state", 32'd0);
        expect_val("post_abort_ball", 32'd0);
        expect_val("ball_wide", 32'd0);
        frames(2);
        check(32'(bus.state));
        check(32'(ball_cnt - ball_base));
        check(32'(ball_wide));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
